rs_multi: RTL and testbench
===========================

Name: rs_multi

Overview:
- Parametrised successor reservation station for the out-of-order core.
- Sits between decode/ROB-allocate and one execution unit.
- Holds ENTRIES operations, each with NSRC data operands plus one flags operand.
- Snoops NBCAST completion buses and captures results by tag.
- Issues the oldest fully-ready entry through a registered valid/ready output stage.
- Adds a flush and a same-cycle assign/broadcast bypass.

Parameters:
- DATAW, 32, operand width.
- FLAGSW, 4, flags operand width (>=1).
- TAGW, 6, producer tag width.
- EXTRAW, 18, opaque payload (opcode, dest tag) carried to issue.
- ENTRIES, 8, station depth (>=2, any integer).
- NSRC, 2, data operands per entry (1..3).
- NBCAST, 2, broadcast buses.
- CNTW, $clog2(ENTRIES+1), occupancy counter width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- flush  in  1  discard all entries and the output stage.
- in_valid  in  1  dispatch request.
- in_ready  out  1  asserted when occupancy < ENTRIES.
- in_src_valid  in  NSRC  per-operand "value already known".
- in_src_tag  in  NSRC*TAGW  operand i at [i*TAGW +: TAGW].
- in_src_value  in  NSRC*DATAW  operand values.
- in_flags_valid  in  1  flags value already known.
- in_flags_tag  in  TAGW  flags producer tag.
- in_flags_value  in  FLAGSW  flags value.
- in_extra  in  EXTRAW  payload.
- bc_en  in  NBCAST  per-bus broadcast strobe.
- bc_tag  in  NBCAST*TAGW  broadcast tags.
- bc_value  in  NBCAST*DATAW  broadcast results.
- bc_flags  in  NBCAST*FLAGSW  broadcast flags.
- out_valid  out  1  issue stage holds an operation.
- out_ready  in  1  execution unit accepts.
- out_src  out  NSRC*DATAW  issued operand values.
- out_flags  out  FLAGSW  issued flags.
- out_extra  out  EXTRAW  issued payload.
- count  out  CNTW  occupied entries (excludes the output stage).

Behaviour:
- Reset: all entries free; count=0; out_valid=0; in_ready=1; out_src/out_flags/out_extra=0; age matrix cleared. rst has priority over flush; flush over everything else.
- Entry state: alloc bit, per-operand {valid, tag, value}, flags {valid, tag, value}, extra.
- Entry ready = alloc & all operand valids & flags valid.
- Dispatch:
  - Fires when in_valid & in_ready.
  - Writes the lowest-index free entry (free set taken from registered state, so a slot freed this cycle is not reusable this cycle).
  - Sets the new entry younger than all currently allocated entries in the age matrix.
  - in_valid while full is ignored, with no state change.
- Bypass: a dispatched operand with valid=0 whose tag equals an enabled bc_tag in the same cycle is stored valid=1 with that bus's value/flags.
- Capture:
  - Each cycle, every allocated entry operand with valid=0 compares its tag against all enabled buses.
  - On a match, the operand latches the value and sets valid=1.
  - Multiple buses matching: lowest bus index wins.
  - Already-valid operands ignore broadcasts.
- Select:
  - Candidate = oldest ready entry per the age matrix.
  - The output stage loads when (!out_valid | out_ready) and a candidate exists.
  - On load, the selected entry is freed the same edge.
  - An entry that becomes ready at edge N can be on out_valid at edge N+1 earliest (one-cycle select latency).
  - If the stage drains with no candidate: out_valid<=0; data outputs hold last values.
- Output handshake: out_* stable while out_valid & !out_ready. Transfer = out_valid & out_ready. Back-to-back issue every cycle when entries are ready.
- Count: count_next = count + dispatch − select. Simultaneous dispatch and select leaves count unchanged. Saturation cannot occur; count==ENTRIES deasserts in_ready.
- Flush: next cycle all alloc=0, count=0, out_valid=0. Dispatch, select and capture in the flush cycle are discarded.
- Tags are not cleared on free; stale entries never match because alloc=0 gates capture.

Test Plan:
- Reset then dispatch srcs valid {5,7}, flags valid 0x3, extra 0x11 -> out_valid at edge 2 after dispatch with out_src={5,7}, out_flags=0x3, out_extra=0x11; count back to 0.
- Dispatch A waiting tag 9 and B waiting tag 9. Broadcast bus1 tag 9 value 0xDEAD -> both capture. A issues first (older), B next cycle. A's out_src[0]=0xDEAD.
- Fill ENTRIES=8 with unready ops -> in_ready=0, count=8. A 9th in_valid is ignored. Then broadcast wakes one -> after it issues, in_ready=1 and count=7.
- Dispatch with src0 tag 4 invalid while bc_en[0] tag 4 value 0x55 in the same cycle -> entry stored valid, issues without a further broadcast, out_src[0]=0x55.
- Hold out_ready=0 with 3 ready entries -> out_* stable, count=2. Then out_ready=1 for 3 cycles -> 3 transfers in oldest order, count=0.
- Flush with 5 entries and out_valid=1, plus a dispatch the same cycle -> next cycle count=0 and out_valid=0. Subsequent broadcasts produce no issue.

Source files
------------

// File: rtl/rs_multi.sv
// rs_multi: reservation station for one execution unit.
// Holds ENTRIES operations (NSRC data operands + one flags operand each),
// captures producer results from NBCAST broadcast buses by tag, and issues
// the oldest fully-ready entry through a registered valid/ready stage.
// Ports:
//   clk, rst (sync, active-high), flush
//   in_*   : dispatch interface (in_valid/in_ready, operands, flags, payload)
//   bc_*   : broadcast buses (enable, tag, value, flags per bus)
//   out_*  : issue interface (out_valid/out_ready, operands, flags, payload)
//   count  : occupied entries, output stage excluded
module rs_multi #(
  parameter int unsigned DATAW   = 32,
  parameter int unsigned FLAGSW  = 4,
  parameter int unsigned TAGW    = 6,
  parameter int unsigned EXTRAW  = 18,
  parameter int unsigned ENTRIES = 8,
  parameter int unsigned NSRC    = 2,
  parameter int unsigned NBCAST  = 2,
  parameter int unsigned CNTW    = $clog2(ENTRIES + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [NSRC-1:0]          in_src_valid,
  input  logic [NSRC*TAGW-1:0]     in_src_tag,
  input  logic [NSRC*DATAW-1:0]    in_src_value,
  input  logic                     in_flags_valid,
  input  logic [TAGW-1:0]          in_flags_tag,
  input  logic [FLAGSW-1:0]        in_flags_value,
  input  logic [EXTRAW-1:0]        in_extra,
  input  logic [NBCAST-1:0]        bc_en,
  input  logic [NBCAST*TAGW-1:0]   bc_tag,
  input  logic [NBCAST*DATAW-1:0]  bc_value,
  input  logic [NBCAST*FLAGSW-1:0] bc_flags,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [NSRC*DATAW-1:0]    out_src,
  output logic [FLAGSW-1:0]        out_flags,
  output logic [EXTRAW-1:0]        out_extra,
  output logic [CNTW-1:0]          count
);

  localparam int unsigned IDXW  = $clog2(ENTRIES);
  localparam int unsigned BIDXW = (NBCAST > 1) ? $clog2(NBCAST) : 1;

  // Entry storage
  logic [ENTRIES-1:0] alloc_q, alloc_d;
  // older_q[i][j] = 1 means entry i was allocated before entry j
  logic [ENTRIES-1:0] older_q [ENTRIES];
  logic [ENTRIES-1:0] older_d [ENTRIES];
  logic [NSRC-1:0]    src_v_q [ENTRIES];
  logic [NSRC-1:0]    src_v_d [ENTRIES];
  logic [TAGW-1:0]    src_tag_q [ENTRIES][NSRC];
  logic [TAGW-1:0]    src_tag_d [ENTRIES][NSRC];
  logic [DATAW-1:0]   src_val_q [ENTRIES][NSRC];
  logic [DATAW-1:0]   src_val_d [ENTRIES][NSRC];
  logic [ENTRIES-1:0] flg_v_q, flg_v_d;
  logic [TAGW-1:0]    flg_tag_q [ENTRIES];
  logic [TAGW-1:0]    flg_tag_d [ENTRIES];
  logic [FLAGSW-1:0]  flg_val_q [ENTRIES];
  logic [FLAGSW-1:0]  flg_val_d [ENTRIES];
  logic [EXTRAW-1:0]  extra_q [ENTRIES];
  logic [EXTRAW-1:0]  extra_d [ENTRIES];

  // Output stage and occupancy
  logic                   out_valid_q, out_valid_d;
  logic [NSRC*DATAW-1:0]  out_src_q, out_src_d;
  logic [FLAGSW-1:0]      out_flags_q, out_flags_d;
  logic [EXTRAW-1:0]      out_extra_q, out_extra_d;
  logic [CNTW-1:0]        count_q, count_d;

  logic [ENTRIES-1:0] ready;
  logic [ENTRIES-1:0] cand;
  logic               has_cand;
  logic               load;
  logic               dispatch;
  logic [IDXW-1:0]    sel_idx;
  logic [IDXW-1:0]    free_idx;

  // First enabled bus whose tag matches; MSB is the hit flag.
  function automatic logic [BIDXW:0] bc_lookup(input logic [TAGW-1:0] tag);
    logic [BIDXW:0] r;
    r = '0;
    for (int unsigned b = 0; b < NBCAST; b++) begin
      if (!r[BIDXW] && bc_en[b] && (bc_tag[b*TAGW +: TAGW] == tag)) begin
        r = {1'b1, BIDXW'(b)};
      end
    end
    return r;
  endfunction

  assign in_ready  = (count_q < CNTW'(ENTRIES));
  assign dispatch  = in_valid & in_ready;
  assign out_valid = out_valid_q;
  assign out_src   = out_src_q;
  assign out_flags = out_flags_q;
  assign out_extra = out_extra_q;
  assign count     = count_q;

  // Readiness and oldest-ready selection; readiness comes from registered
  // state only, which gives the one-cycle select latency.
  always_comb begin
    logic [ENTRIES-1:0] others;
    logic               found_sel;
    logic               found_free;
    others     = '0;
    ready      = '0;
    cand       = '0;
    sel_idx    = '0;
    free_idx   = '0;
    found_sel  = 1'b0;
    found_free = 1'b0;
    for (int unsigned i = 0; i < ENTRIES; i++) begin
      ready[i] = alloc_q[i] & (&src_v_q[i]) & flg_v_q[i];
    end
    for (int unsigned i = 0; i < ENTRIES; i++) begin
      others    = ready;
      others[i] = 1'b0;
      // candidate if no other ready entry is older than this one
      cand[i]   = ready[i] & ~(|(others & ~older_q[i]));
    end
    for (int unsigned i = 0; i < ENTRIES; i++) begin
      if (!found_sel && cand[i]) begin
        found_sel = 1'b1;
        sel_idx   = IDXW'(i);
      end
      if (!found_free && !alloc_q[i]) begin
        found_free = 1'b1;
        free_idx   = IDXW'(i);
      end
    end
  end

  assign has_cand = |ready;
  assign load     = (!out_valid_q || out_ready) && has_cand;

  always_comb begin
    logic [BIDXW:0]  lk;
    int unsigned     bi;
    logic [TAGW-1:0] tag;
    lk          = '0;
    bi          = 0;
    tag         = '0;
    alloc_d     = alloc_q;
    older_d     = older_q;
    src_v_d     = src_v_q;
    src_tag_d   = src_tag_q;
    src_val_d   = src_val_q;
    flg_v_d     = flg_v_q;
    flg_tag_d   = flg_tag_q;
    flg_val_d   = flg_val_q;
    extra_d     = extra_q;
    out_valid_d = out_valid_q;
    out_src_d   = out_src_q;
    out_flags_d = out_flags_q;
    out_extra_d = out_extra_q;
    count_d     = count_q;

    // Capture: only allocated, still-waiting operands listen to the buses
    for (int unsigned i = 0; i < ENTRIES; i++) begin
      if (alloc_q[i]) begin
        for (int unsigned s = 0; s < NSRC; s++) begin
          if (!src_v_q[i][s]) begin
            lk = bc_lookup(src_tag_q[i][s]);
            if (lk[BIDXW]) begin
              bi              = int'(lk[BIDXW-1:0]);
              src_v_d[i][s]   = 1'b1;
              src_val_d[i][s] = bc_value[bi*DATAW +: DATAW];
            end
          end
        end
        if (!flg_v_q[i]) begin
          lk = bc_lookup(flg_tag_q[i]);
          if (lk[BIDXW]) begin
            bi           = int'(lk[BIDXW-1:0]);
            flg_v_d[i]   = 1'b1;
            flg_val_d[i] = bc_flags[bi*FLAGSW +: FLAGSW];
          end
        end
      end
    end

    // Select into the output stage
    if (load) begin
      alloc_d[sel_idx] = 1'b0;
      out_valid_d      = 1'b1;
      for (int unsigned s = 0; s < NSRC; s++) begin
        out_src_d[s*DATAW +: DATAW] = src_val_q[sel_idx][s];
      end
      out_flags_d = flg_val_q[sel_idx];
      out_extra_d = extra_q[sel_idx];
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end

    // Dispatch into the lowest free slot, with same-cycle broadcast bypass
    if (dispatch) begin
      alloc_d[free_idx] = 1'b1;
      older_d[free_idx] = '0;
      for (int unsigned j = 0; j < ENTRIES; j++) begin
        older_d[j][free_idx] = alloc_q[j];
      end
      for (int unsigned s = 0; s < NSRC; s++) begin
        tag                    = in_src_tag[s*TAGW +: TAGW];
        src_tag_d[free_idx][s] = tag;
        src_v_d[free_idx][s]   = in_src_valid[s];
        src_val_d[free_idx][s] = in_src_value[s*DATAW +: DATAW];
        if (!in_src_valid[s]) begin
          lk = bc_lookup(tag);
          if (lk[BIDXW]) begin
            bi                     = int'(lk[BIDXW-1:0]);
            src_v_d[free_idx][s]   = 1'b1;
            src_val_d[free_idx][s] = bc_value[bi*DATAW +: DATAW];
          end
        end
      end
      flg_tag_d[free_idx] = in_flags_tag;
      flg_v_d[free_idx]   = in_flags_valid;
      flg_val_d[free_idx] = in_flags_value;
      if (!in_flags_valid) begin
        lk = bc_lookup(in_flags_tag);
        if (lk[BIDXW]) begin
          bi                  = int'(lk[BIDXW-1:0]);
          flg_v_d[free_idx]   = 1'b1;
          flg_val_d[free_idx] = bc_flags[bi*FLAGSW +: FLAGSW];
        end
      end
      extra_d[free_idx] = in_extra;
    end

    count_d = count_q + CNTW'(dispatch) - CNTW'(load);

    // Flush drops everything decided this cycle; data outputs keep old values
    if (flush) begin
      alloc_d     = '0;
      count_d     = '0;
      out_valid_d = 1'b0;
      out_src_d   = out_src_q;
      out_flags_d = out_flags_q;
      out_extra_d = out_extra_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      alloc_q     <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      out_src_q   <= '0;
      out_flags_q <= '0;
      out_extra_q <= '0;
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        older_q[i] <= '0;
      end
    end else begin
      alloc_q     <= alloc_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      out_src_q   <= out_src_d;
      out_flags_q <= out_flags_d;
      out_extra_q <= out_extra_d;
      older_q     <= older_d;
    end
  end

  // Payload needs no reset: alloc gates every use of it
  always_ff @(posedge clk) begin
    src_v_q   <= src_v_d;
    src_tag_q <= src_tag_d;
    src_val_q <= src_val_d;
    flg_v_q   <= flg_v_d;
    flg_tag_q <= flg_tag_d;
    flg_val_q <= flg_val_d;
    extra_q   <= extra_d;
  end

endmodule

// File: tb/tb_rs_multi.sv
// Self-checking bench for rs_multi (default parameters).
module tb_rs_multi;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_src_valid;
  logic [11:0] in_src_tag;
  logic [63:0] in_src_value;
  logic        in_flags_valid;
  logic [5:0]  in_flags_tag;
  logic [3:0]  in_flags_value;
  logic [17:0] in_extra;
  logic [1:0]  bc_en;
  logic [11:0] bc_tag;
  logic [63:0] bc_value;
  logic [7:0]  bc_flags;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_src;
  logic [3:0]  out_flags;
  logic [17:0] out_extra;
  logic [3:0]  count;

  int n_checks = 0;
  int n_pass   = 0;
  logic [127:0] sb[$];

  rs_multi #(
    .DATAW(32), .FLAGSW(4), .TAGW(6), .EXTRAW(18),
    .ENTRIES(8), .NSRC(2), .NBCAST(2)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_src_valid(in_src_valid), .in_src_tag(in_src_tag), .in_src_value(in_src_value),
    .in_flags_valid(in_flags_valid), .in_flags_tag(in_flags_tag),
    .in_flags_value(in_flags_value), .in_extra(in_extra),
    .bc_en(bc_en), .bc_tag(bc_tag), .bc_value(bc_value), .bc_flags(bc_flags),
    .out_valid(out_valid), .out_ready(out_ready), .out_src(out_src),
    .out_flags(out_flags), .out_extra(out_extra), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else n_pass++;
  endtask

  function automatic logic [127:0] pk(input logic [31:0] s0, input logic [31:0] s1,
                                      input logic [3:0] f, input logic [17:0] x);
    return {42'd0, s1, s0, f, x};
  endfunction

  function automatic logic [127:0] obs();
    return {42'd0, out_src, out_flags, out_extra};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic disp(input logic v0, input logic [5:0] t0, input logic [31:0] d0,
                      input logic v1, input logic [5:0] t1, input logic [31:0] d1,
                      input logic fv, input logic [5:0] ft, input logic [3:0] fd,
                      input logic [17:0] x);
    in_valid       = 1'b1;
    in_src_valid   = {v1, v0};
    in_src_tag     = {t1, t0};
    in_src_value   = {d1, d0};
    in_flags_valid = fv;
    in_flags_tag   = ft;
    in_flags_value = fd;
    in_extra       = x;
    step();
    in_valid = 1'b0;
  endtask

  task automatic bc(input int bus, input logic [5:0] t, input logic [31:0] v, input logic [3:0] f);
    bc_en[bus]            = 1'b1;
    bc_tag[bus*6 +: 6]    = t;
    bc_value[bus*32 +: 32] = v;
    bc_flags[bus*4 +: 4]  = f;
    step();
    bc_en = '0;
  endtask

  task automatic wait_drain(input string tag);
    for (int k = 0; k < 40; k++) begin
      if (sb.size() == 0 && !out_valid) break;
      step();
    end
    chk(tag, {95'd0, out_valid, sb.size()}, 128'd0);
  endtask

  // Scoreboard: a transfer happens at the next posedge when both are high
  always @(negedge clk) begin
    logic [127:0] e;
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) chk("sb_underflow", 128'(sb.size()), 128'd1);
      else begin
        e = sb.pop_front();
        chk("issue", obs(), e);
      end
    end
  end

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_src_valid = '0; in_src_tag = '0; in_src_value = '0;
    in_flags_valid = 1'b0; in_flags_tag = '0; in_flags_value = '0; in_extra = '0;
    bc_en = '0; bc_tag = '0; bc_value = '0; bc_flags = '0;
    repeat (3) step();
    chk("rst_out_valid", 128'(out_valid), 128'd0);
    chk("rst_in_ready", 128'(in_ready), 128'd1);
    chk("rst_count", 128'(count), 128'd0);
    chk("rst_data", obs(), 128'd0);
    rst = 1'b0;
    step();

    // Basic: ready at dispatch, issues one edge after the dispatch edge
    sb.push_back(pk(32'd5, 32'd7, 4'h3, 18'h11));
    disp(1, 6'd0, 32'd5, 1, 6'd0, 32'd7, 1, 6'd0, 4'h3, 18'h11);
    chk("t1_count_after_disp", 128'(count), 128'd1);
    chk("t1_latency_low", 128'(out_valid), 128'd0);
    step();
    chk("t1_out_valid", 128'(out_valid), 128'd1);
    chk("t1_count_zero", 128'(count), 128'd0);
    wait_drain("t1_drain");

    // Two waiters on tag 9 wake together; older issues first
    disp(0, 6'd9, 32'd0, 1, 6'd0, 32'd1, 0, 6'd30, 4'h0, 18'hA);
    disp(0, 6'd9, 32'd0, 1, 6'd0, 32'd2, 1, 6'd0, 4'h1, 18'hB);
    step();
    chk("t2_waiting", {126'd0, out_valid, 1'b0}, 128'd0);
    chk("t2_count", 128'(count), 128'd2);
    // A's flags wait on tag 30; wake it first via bus 0, then tag 9 on bus 1
    bc(0, 6'd30, 32'h0, 4'h2);
    sb.push_back(pk(32'hDEAD, 32'd1, 4'h2, 18'hA));
    sb.push_back(pk(32'hDEAD, 32'd2, 4'h1, 18'hB));
    bc(1, 6'd9, 32'hDEAD, 4'hF);
    step();
    chk("t2_first_src0", 128'(out_src[31:0]), 128'hDEAD);
    chk("t2_first_extra", 128'(out_extra), 128'hA);
    wait_drain("t2_drain");

    // Lowest bus wins on a double match; flags captured separately
    disp(0, 6'd12, 32'd0, 1, 6'd0, 32'd3, 0, 6'd13, 4'h0, 18'hC);
    bc_en = 2'b11;
    bc_tag = {6'd12, 6'd12};
    bc_value = {32'h222, 32'h111};
    bc_flags = {4'h6, 4'h5};
    step();
    bc_en = '0;
    sb.push_back(pk(32'h111, 32'd3, 4'h9, 18'hC));
    bc(1, 6'd13, 32'h999, 4'h9);
    wait_drain("t2b_drain");

    // Fill with unready ops, ignored 9th dispatch, wake one
    for (int i = 0; i < 8; i++)
      disp(0, 6'(20 + i), 32'd0, 1, 6'd0, 32'(i), 1, 6'd0, 4'(i), 18'(12'h300 + i));
    chk("t3_full_count", 128'(count), 128'd8);
    chk("t3_full_in_ready", 128'(in_ready), 128'd0);
    disp(1, 6'd0, 32'h77, 1, 6'd0, 32'h78, 1, 6'd0, 4'h7, 18'h3FF);
    step();
    chk("t3_ignored_count", 128'(count), 128'd8);
    chk("t3_ignored_no_issue", 128'(out_valid), 128'd0);
    sb.push_back(pk(32'h333, 32'd3, 4'd3, 18'h303));
    bc(0, 6'd23, 32'h333, 4'h0);
    chk("t3_wake_count", 128'(count), 128'd8);
    step();
    chk("t3_after_issue_count", 128'(count), 128'd7);
    chk("t3_after_issue_in_ready", 128'(in_ready), 128'd1);
    for (int i = 0; i < 8; i++) begin
      if (i != 3) begin
        sb.push_back(pk(32'(16'h5000 + i), 32'(i), 4'(i), 18'(12'h300 + i)));
        bc(i % 2, 6'(20 + i), 32'(16'h5000 + i), 4'h0);
      end
    end
    wait_drain("t3_drain");
    chk("t3_final_count", 128'(count), 128'd0);

    // Same-cycle bypass on dispatch
    bc_en = 2'b01; bc_tag = {6'd0, 6'd4}; bc_value = {32'h0, 32'h55}; bc_flags = 8'h0;
    sb.push_back(pk(32'h55, 32'h66, 4'h1, 18'h44));
    disp(0, 6'd4, 32'd0, 1, 6'd0, 32'h66, 1, 6'd0, 4'h1, 18'h44);
    bc_en = '0;
    step();
    chk("t4_bypass_issue", 128'(out_valid), 128'd1);
    wait_drain("t4_drain");

    // Backpressure: stage holds, then three transfers in order
    out_ready = 1'b0;
    sb.push_back(pk(32'h100, 32'h101, 4'h1, 18'h1));
    disp(1, 6'd0, 32'h100, 1, 6'd0, 32'h101, 1, 6'd0, 4'h1, 18'h1);
    sb.push_back(pk(32'h200, 32'h201, 4'h2, 18'h2));
    disp(1, 6'd0, 32'h200, 1, 6'd0, 32'h201, 1, 6'd0, 4'h2, 18'h2);
    sb.push_back(pk(32'h300, 32'h301, 4'h3, 18'h3));
    disp(1, 6'd0, 32'h300, 1, 6'd0, 32'h301, 1, 6'd0, 4'h3, 18'h3);
    step();
    chk("t5_hold_valid", 128'(out_valid), 128'd1);
    chk("t5_hold_data", obs(), pk(32'h100, 32'h101, 4'h1, 18'h1));
    chk("t5_hold_count", 128'(count), 128'd2);
    step(); step();
    chk("t5_still_stable", obs(), pk(32'h100, 32'h101, 4'h1, 18'h1));
    out_ready = 1'b1;
    step(); step(); step();
    chk("t5_done_count", 128'(count), 128'd0);
    chk("t5_done_valid", 128'(out_valid), 128'd0);
    chk("t5_sb_empty", 128'(sb.size()), 128'd0);

    // Flush with stalled output stage and a same-cycle dispatch
    out_ready = 1'b0;
    disp(1, 6'd0, 32'hF0, 1, 6'd0, 32'hF1, 1, 6'd0, 4'hF, 18'hF);
    for (int i = 0; i < 5; i++)
      disp(0, 6'(40 + i), 32'd0, 1, 6'd0, 32'(i), 1, 6'd0, 4'h0, 18'h0);
    chk("t6_pre_count", 128'(count), 128'd5);
    chk("t6_pre_valid", 128'(out_valid), 128'd1);
    flush = 1'b1;
    disp(1, 6'd0, 32'hE0, 1, 6'd0, 32'hE1, 1, 6'd0, 4'hE, 18'hE);
    flush = 1'b0;
    chk("t6_flush_count", 128'(count), 128'd0);
    chk("t6_flush_valid", 128'(out_valid), 128'd0);
    chk("t6_flush_in_ready", 128'(in_ready), 128'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) bc(0, 6'(40 + i), 32'hBAD, 4'h0);
    step(); step();
    chk("t6_no_issue", 128'(out_valid), 128'd0);
    chk("t6_post_count", 128'(count), 128'd0);

    step();
    chk("sb_left", 128'(sb.size()), 128'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
